// File: rtl/vgafb_pkg.sv
// Shared constants for the multi-layer VGA framebuffer CSR interface:
// CSR offsets, layer window layout, default timing and irq bit positions.
package vgafb_pkg;

    // Global CSR offsets (csr_a[5:0])
    localparam logic [5:0] OFS_VGA_RST  = 6'h00;
    localparam logic [5:0] OFS_TIM_LO   = 6'h01;
    localparam logic [5:0] OFS_TIM_HI   = 6'h08;
    localparam logic [5:0] OFS_COMMIT   = 6'h09;
    localparam logic [5:0] OFS_DDC      = 6'h0A;
    localparam logic [5:0] OFS_CLKSEL   = 6'h0B;
    localparam logic [5:0] OFS_IRQ_STAT = 6'h0C;
    localparam logic [5:0] OFS_IRQ_MASK = 6'h0D;

    // Layer window: 0x10 + 4*k, four registers per layer
    localparam logic [1:0] LAYER_WIN    = 2'b01;
    localparam int         LAYER_STRIDE = 4;
    localparam logic [1:0] LOFS_BASE    = 2'd0;
    localparam logic [1:0] LOFS_ACT     = 2'd1;
    localparam logic [1:0] LOFS_NBURSTS = 2'd2;
    localparam logic [1:0] LOFS_EN      = 2'd3;

    // Interrupt status/mask bit positions
    localparam int IRQ_FRAME_BIT = 0;
    localparam int IRQ_FLIP_BIT  = 8;

    localparam int          NTIMING     = 8;
    localparam logic [17:0] NBURSTS_RST = 18'd19200;

    typedef enum logic [2:0] {
        T_HRES,
        T_HSYNC_START,
        T_HSYNC_END,
        T_HSCAN,
        T_VRES,
        T_VSYNC_START,
        T_VSYNC_END,
        T_VSCAN
    } timing_e;

    // 640x480 @ 60 Hz defaults, indexed by timing_e
    function automatic logic [31:0] def_timing(input logic [2:0] idx);
        logic [31:0] v;
        v = 32'd0;
        case (idx)
            T_HRES:        v = 32'd640;
            T_HSYNC_START: v = 32'd656;
            T_HSYNC_END:   v = 32'd752;
            T_HSCAN:       v = 32'd799;
            T_VRES:        v = 32'd480;
            T_VSYNC_START: v = 32'd491;
            T_VSYNC_END:   v = 32'd493;
            T_VSCAN:       v = 32'd523;
            default:       v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vgafb_ctlif_layer.sv
// One framebuffer layer: base address (requested/acknowledged), burst
// count, enable and flip-done flag, plus its 4-register read mux.
// Ports: clk/rst, we/addr/di (pre-decoded CSR write), ack (scanner latched
// base), flip_clr (W1C), rdata, baseaddress, nbursts, enable, flip.
module vgafb_ctlif_layer
    import vgafb_pkg::*;
#(
    parameter int   fml_depth = 26,
    parameter logic en_rst    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [1:0]           addr,
    input  logic [31:0]          di,
    input  logic                 ack,
    input  logic                 flip_clr,
    output logic [31:0]          rdata,
    output logic [fml_depth-1:0] baseaddress,
    output logic [17:0]          nbursts,
    output logic                 enable,
    output logic                 flip
);

    logic [fml_depth-1:0] base_q, base_d;
    logic [fml_depth-1:0] act_q, act_d;
    logic [17:0]          nb_q, nb_d;
    logic                 en_q, en_d;
    logic                 flip_q, flip_d;

    // Upper data bits above the address width are intentionally ignored
    logic unused_di;
    assign unused_di = ^di;

    always_comb begin
        base_d = base_q;
        act_d  = act_q;
        nb_d   = nb_q;
        en_d   = en_q;
        flip_d = flip_q;
        if (we) begin
            unique case (addr)
                LOFS_BASE:    base_d = di[fml_depth-1:0];
                LOFS_NBURSTS: nb_d   = di[17:0];
                LOFS_EN:      en_d   = di[0];
                LOFS_ACT:     ;
            endcase
        end
        // Ack captures the base the scanner saw, i.e. the old register value
        if (ack) act_d = base_q;
        // A coincident ack wins over the W1C clear
        if (flip_clr) flip_d = 1'b0;
        if (ack)      flip_d = 1'b1;
    end

    always_comb begin
        rdata = 32'd0;
        unique case (addr)
            LOFS_BASE:    rdata[fml_depth-1:0] = base_q;
            LOFS_ACT:     rdata[fml_depth-1:0] = act_q;
            LOFS_NBURSTS: rdata[17:0]          = nb_q;
            LOFS_EN:      rdata[0]             = en_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            act_q  <= '0;
            nb_q   <= NBURSTS_RST;
            en_q   <= en_rst;
            flip_q <= 1'b0;
        end else begin
            base_q <= base_d;
            act_q  <= act_d;
            nb_q   <= nb_d;
            en_q   <= en_d;
            flip_q <= flip_d;
        end
    end

    assign baseaddress = base_q;
    assign nbursts     = nb_q;
    assign enable      = en_q;
    assign flip        = flip_q;

endmodule

// File: rtl/vgafb_ctlif_ml.sv
// Frame-synchronous CSR control for the VGA framebuffer: shadow timing
// committed at frame start, N layers, maskable irq, bit-banged DDC.
// Ports: sys_clk/sys_rst, CSR bus (csr_a/we/di/do), irq, vga_rst, eight
// timing outputs, frame_start, per-layer base/ack/nbursts/enable, DDC, clksel.
module vgafb_ctlif_ml
    import vgafb_pkg::*;
#(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int         fml_depth = 26,
    parameter int         hw        = 12,
    parameter int         layers    = 2
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [13:0]                 csr_a,
    input  logic                        csr_we,
    input  logic [31:0]                 csr_di,
    output logic [31:0]                 csr_do,
    output logic                        irq,
    output logic                        vga_rst,
    output logic [hw-1:0]               hres,
    output logic [hw-1:0]               hsync_start,
    output logic [hw-1:0]               hsync_end,
    output logic [hw-1:0]               hscan,
    output logic [hw-1:0]               vres,
    output logic [hw-1:0]               vsync_start,
    output logic [hw-1:0]               vsync_end,
    output logic [hw-1:0]               vscan,
    input  logic                        frame_start,
    output logic [layers*fml_depth-1:0] baseaddress,
    input  logic [layers-1:0]           baseaddress_ack,
    output logic [layers*18-1:0]        nbursts,
    output logic [layers-1:0]           layer_en,
    inout  wire                         vga_sda,
    output logic                        vga_sdc,
    output logic [1:0]                  clksel
);

    logic       csr_sel;
    logic [5:0] ofs;
    logic       wr;
    logic       tim_hit;
    logic [2:0] tim_idx;
    logic       layer_hit;
    logic [1:0] layer_idx;
    logic       copy;

    logic unused_a;
    assign unused_a = ^csr_a[9:6];

    assign csr_sel   = (csr_a[13:10] == csr_addr);
    assign ofs       = csr_a[5:0];
    assign wr        = csr_sel & csr_we;
    assign tim_hit   = (ofs >= OFS_TIM_LO) && (ofs <= OFS_TIM_HI);
    // Offsets 1..8 map to timing index 0..7 (8 wraps to 7 in 3 bits)
    assign tim_idx   = 3'(ofs[2:0] - 3'd1);
    assign layer_hit = (ofs[5:4] == LAYER_WIN);
    assign layer_idx = ofs[3:2];

    logic [hw-1:0] shadow_q [NTIMING];
    logic [hw-1:0] shadow_d [NTIMING];
    logic [hw-1:0] active_q [NTIMING];
    logic [hw-1:0] active_d [NTIMING];

    logic              vga_rst_q, vga_rst_d;
    logic              commit_q, commit_d;
    logic              sdc_q, sdc_d;
    logic              sda_oe_q, sda_oe_d;
    logic              sda_o_q, sda_o_d;
    logic              sda_s1_q, sda_s2_q;
    logic [1:0]        clksel_q, clksel_d;
    logic              fstat_q, fstat_d;
    logic              fmask_q, fmask_d;
    logic [layers-1:0] lmask_q, lmask_d;
    logic              irq_q, irq_d;
    logic [31:0]       csr_do_q, csr_do_d;

    logic [layers-1:0] l_we;
    logic [layers-1:0] l_flip;
    logic [layers-1:0] l_clr;
    logic [31:0]       l_rdata [layers];

    // While vga_rst is held the timing follows the shadows every cycle
    assign copy = (commit_q & frame_start) | vga_rst_q;

    for (genvar k = 0; k < layers; k++) begin : g_layer
        assign l_we[k]  = wr && layer_hit && (layer_idx == 2'(k));
        assign l_clr[k] = wr && (ofs == OFS_IRQ_STAT)
                          && csr_di[IRQ_FLIP_BIT+k];

        vgafb_ctlif_layer #(
            .fml_depth (fml_depth),
            .en_rst    (k == 0)
        ) u_layer (
            .clk         (sys_clk),
            .rst         (sys_rst),
            .we          (l_we[k]),
            .addr        (ofs[1:0]),
            .di          (csr_di),
            .ack         (baseaddress_ack[k]),
            .flip_clr    (l_clr[k]),
            .rdata       (l_rdata[k]),
            .baseaddress (baseaddress[k*fml_depth +: fml_depth]),
            .nbursts     (nbursts[k*18 +: 18]),
            .enable      (layer_en[k]),
            .flip        (l_flip[k])
        );
    end

    always_comb begin
        for (int i = 0; i < NTIMING; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
        end
        vga_rst_d = vga_rst_q;
        commit_d  = commit_q;
        sdc_d     = sdc_q;
        sda_oe_d  = sda_oe_q;
        sda_o_d   = sda_o_q;
        clksel_d  = clksel_q;
        fstat_d   = fstat_q;
        fmask_d   = fmask_q;
        lmask_d   = lmask_q;

        // Copy uses the pre-write shadow values
        if (copy) begin
            for (int i = 0; i < NTIMING; i++) active_d[i] = shadow_q[i];
            commit_d = 1'b0;
        end

        if (wr) begin
            if (tim_hit) shadow_d[tim_idx] = csr_di[hw-1:0];
            case (ofs)
                OFS_VGA_RST: vga_rst_d = csr_di[0];
                OFS_COMMIT:  if (csr_di[0]) commit_d = 1'b1;
                OFS_DDC: begin
                    sdc_d    = csr_di[3];
                    sda_oe_d = csr_di[2];
                    sda_o_d  = csr_di[1];
                end
                OFS_CLKSEL:  clksel_d = csr_di[1:0];
                OFS_IRQ_STAT: if (csr_di[IRQ_FRAME_BIT]) fstat_d = 1'b0;
                OFS_IRQ_MASK: begin
                    fmask_d = csr_di[IRQ_FRAME_BIT];
                    for (int k = 0; k < layers; k++)
                        lmask_d[k] = csr_di[IRQ_FLIP_BIT+k];
                end
                default: ;
            endcase
        end

        if (frame_start) fstat_d = 1'b1;

        irq_d = (fstat_q & fmask_q) | (|(l_flip & lmask_q));

        csr_do_d = 32'd0;
        if (tim_hit) csr_do_d[hw-1:0] = shadow_q[tim_idx];
        case (ofs)
            OFS_VGA_RST: csr_do_d[0] = vga_rst_q;
            OFS_COMMIT:  csr_do_d[0] = commit_q;
            OFS_DDC:
                csr_do_d[3:0] = {sdc_q, sda_oe_q, sda_o_q, sda_s2_q};
            OFS_CLKSEL:  csr_do_d[1:0] = clksel_q;
            OFS_IRQ_STAT: begin
                csr_do_d[IRQ_FRAME_BIT] = fstat_q;
                for (int k = 0; k < layers; k++)
                    csr_do_d[IRQ_FLIP_BIT+k] = l_flip[k];
            end
            OFS_IRQ_MASK: begin
                csr_do_d[IRQ_FRAME_BIT] = fmask_q;
                for (int k = 0; k < layers; k++)
                    csr_do_d[IRQ_FLIP_BIT+k] = lmask_q[k];
            end
            default: begin
                for (int k = 0; k < layers; k++)
                    if (layer_hit && (layer_idx == 2'(k)))
                        csr_do_d = l_rdata[k];
            end
        endcase
        if (!csr_sel) csr_do_d = 32'd0;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NTIMING; i++) begin
                shadow_q[i] <= hw'(def_timing(3'(i)));
                active_q[i] <= hw'(def_timing(3'(i)));
            end
            vga_rst_q <= 1'b1;
            commit_q  <= 1'b0;
            sdc_q     <= 1'b0;
            sda_oe_q  <= 1'b0;
            sda_o_q   <= 1'b0;
            sda_s1_q  <= 1'b0;
            sda_s2_q  <= 1'b0;
            clksel_q  <= 2'd0;
            fstat_q   <= 1'b0;
            fmask_q   <= 1'b0;
            lmask_q   <= '0;
            irq_q     <= 1'b0;
            csr_do_q  <= 32'd0;
        end else begin
            for (int i = 0; i < NTIMING; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            vga_rst_q <= vga_rst_d;
            commit_q  <= commit_d;
            sdc_q     <= sdc_d;
            sda_oe_q  <= sda_oe_d;
            sda_o_q   <= sda_o_d;
            sda_s1_q  <= vga_sda;
            sda_s2_q  <= sda_s1_q;
            clksel_q  <= clksel_d;
            fstat_q   <= fstat_d;
            fmask_q   <= fmask_d;
            lmask_q   <= lmask_d;
            irq_q     <= irq_d;
            csr_do_q  <= csr_do_d;
        end
    end

    // Open-drain: only ever pull low
    assign vga_sda = (sda_oe_q & ~sda_o_q) ? 1'b0 : 1'bz;

    assign vga_sdc     = sdc_q;
    assign clksel      = clksel_q;
    assign vga_rst     = vga_rst_q;
    assign irq         = irq_q;
    assign csr_do      = csr_do_q;
    assign hres        = active_q[T_HRES];
    assign hsync_start = active_q[T_HSYNC_START];
    assign hsync_end   = active_q[T_HSYNC_END];
    assign hscan       = active_q[T_HSCAN];
    assign vres        = active_q[T_VRES];
    assign vsync_start = active_q[T_VSYNC_START];
    assign vsync_end   = active_q[T_VSYNC_END];
    assign vscan       = active_q[T_VSCAN];

endmodule

// File: tb/tb_vgafb_ctlif_ml.sv
// Directed self-checking bench for vgafb_ctlif_ml (layers=2).
// Hand-computed expectations for CSR, commit, irq, layer and DDC behaviour.
module tb_vgafb_ctlif_ml;

    localparam int FD = 26;
    localparam int HW = 12;
    localparam int NL = 2;

    logic             sys_clk;
    logic             sys_rst;
    logic [13:0]      csr_a;
    logic             csr_we;
    logic [31:0]      csr_di;
    logic [31:0]      csr_do;
    logic             irq;
    logic             vga_rst;
    logic [HW-1:0]    hres, hsync_start, hsync_end, hscan;
    logic [HW-1:0]    vres, vsync_start, vsync_end, vscan;
    logic             frame_start;
    logic [NL*FD-1:0] baseaddress;
    logic [NL-1:0]    baseaddress_ack;
    logic [NL*18-1:0] nbursts;
    logic [NL-1:0]    layer_en;
    wire              sda_w;
    logic             vga_sdc;
    logic [1:0]       clksel;
    logic             tb_pull;

    int n_chk;
    int n_fail;
    logic [31:0] rd;

    pullup (sda_w);
    assign sda_w = tb_pull ? 1'b0 : 1'bz;

    vgafb_ctlif_ml #(
        .csr_addr  (4'h0),
        .fml_depth (FD),
        .hw        (HW),
        .layers    (NL)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .csr_a           (csr_a),
        .csr_we          (csr_we),
        .csr_di          (csr_di),
        .csr_do          (csr_do),
        .irq             (irq),
        .vga_rst         (vga_rst),
        .hres            (hres),
        .hsync_start     (hsync_start),
        .hsync_end       (hsync_end),
        .hscan           (hscan),
        .vres            (vres),
        .vsync_start     (vsync_start),
        .vsync_end       (vsync_end),
        .vscan           (vscan),
        .frame_start     (frame_start),
        .baseaddress     (baseaddress),
        .baseaddress_ack (baseaddress_ack),
        .nbursts         (nbursts),
        .layer_en        (layer_en),
        .vga_sda         (sda_w),
        .vga_sdc         (vga_sdc),
        .clksel          (clksel)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(posedge sys_clk);
        #1 csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [13:0] a, output logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = a;
        csr_we = 1'b0;
        @(posedge sys_clk);
        #1 d = csr_do;
    endtask

    task automatic pulse_fs();
        @(negedge sys_clk);
        frame_start = 1'b1;
        @(posedge sys_clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic pulse_ack(input int k);
        @(negedge sys_clk);
        baseaddress_ack[k] = 1'b1;
        @(posedge sys_clk);
        #1 baseaddress_ack = '0;
    endtask

    initial begin
        logic [31:0] exp_tim [8];
        exp_tim = '{640, 656, 752, 799, 480, 491, 493, 523};
        n_chk = 0;
        n_fail = 0;
        sys_rst = 1'b1;
        csr_a = '0;
        csr_we = 1'b0;
        csr_di = '0;
        frame_start = 1'b0;
        baseaddress_ack = '0;
        tb_pull = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Reset state
        check("rst_vga_rst", 32'(vga_rst), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_csr_do", csr_do, 32'd0);
        check("rst_layer_en", 32'(layer_en), 32'd1);
        check("rst_hres_out", 32'(hres), 32'd640);
        check("rst_vscan_out", 32'(vscan), 32'd523);
        for (int i = 0; i < 8; i++) begin
            csr_rd(14'(i + 1), rd);
            check($sformatf("rst_tim%0d", i + 1), rd, exp_tim[i]);
        end
        csr_rd(14'h12, rd);
        check("rst_nbursts", rd, 32'd19200);

        // Commit applied on frame_start
        csr_wr(14'h00, 32'd0);
        check("vga_rst_cleared", 32'(vga_rst), 32'd0);
        csr_wr(14'h01, 32'd800);
        check("hres_not_yet", 32'(hres), 32'd640);
        csr_rd(14'h01, rd);
        check("hres_shadow", rd, 32'd800);
        csr_wr(14'h09, 32'd1);
        csr_rd(14'h09, rd);
        check("commit_pending", rd, 32'd1);
        @(negedge sys_clk);
        frame_start = 1'b1;
        #1 check("hres_during_fs", 32'(hres), 32'd640);
        @(posedge sys_clk);
        #1 frame_start = 1'b0;
        check("hres_after_fs", 32'(hres), 32'd800);
        csr_rd(14'h09, rd);
        check("commit_cleared", rd, 32'd0);

        // Commit write coincident with frame_start: deferred one frame
        csr_wr(14'h01, 32'd1024);
        @(negedge sys_clk);
        csr_a = 14'h09;
        csr_di = 32'd1;
        csr_we = 1'b1;
        frame_start = 1'b1;
        @(posedge sys_clk);
        #1 csr_we = 1'b0;
        frame_start = 1'b0;
        check("coinc_no_copy", 32'(hres), 32'd800);
        csr_rd(14'h09, rd);
        check("coinc_pending", rd, 32'd1);
        pulse_fs();
        check("coinc_copy_next", 32'(hres), 32'd1024);
        check("hss_unchanged", 32'(hsync_start), 32'd656);

        // Layer 1 flip and irq
        csr_wr(14'h14, 32'h123400);
        check("l1_base_out", 32'(baseaddress[FD +: FD]), 32'h123400);
        csr_wr(14'h0D, 32'h200);
        pulse_ack(1);
        check("irq_lag", 32'(irq), 32'd0);
        @(posedge sys_clk);
        #1 check("irq_set", 32'(irq), 32'd1);
        csr_rd(14'h15, rd);
        check("l1_act", rd, 32'h123400);
        csr_rd(14'h11, rd);
        check("l0_act_idle", rd, 32'd0);
        csr_rd(14'h0C, rd);
        check("status_201", rd, 32'h201);
        csr_wr(14'h0C, 32'h200);
        @(posedge sys_clk);
        #1 check("irq_cleared", 32'(irq), 32'd0);

        // W1C frame bit racing a new frame_start: set wins
        @(negedge sys_clk);
        csr_a = 14'h0C;
        csr_di = 32'd1;
        csr_we = 1'b1;
        frame_start = 1'b1;
        @(posedge sys_clk);
        #1 csr_we = 1'b0;
        frame_start = 1'b0;
        csr_rd(14'h0C, rd);
        check("w1c_vs_set", rd, 32'h1);
        csr_wr(14'h0C, 32'd1);
        csr_rd(14'h0C, rd);
        check("w1c_clear", rd, 32'h0);

        // Base write racing ack on layer 0: act gets the old base
        @(negedge sys_clk);
        csr_a = 14'h10;
        csr_di = 32'h55;
        csr_we = 1'b1;
        baseaddress_ack = 2'b01;
        @(posedge sys_clk);
        #1 csr_we = 1'b0;
        baseaddress_ack = '0;
        csr_rd(14'h11, rd);
        check("l0_act_old", rd, 32'd0);
        csr_rd(14'h10, rd);
        check("l0_base", rd, 32'h55);
        pulse_ack(0);
        csr_rd(14'h11, rd);
        check("l0_act_new", rd, 32'h55);
        check("irq_l0_masked", 32'(irq), 32'd0);
        csr_rd(14'h0C, rd);
        check("status_100", rd, 32'h100);

        // nbursts / enable on layer 1
        csr_wr(14'h16, 32'd1000);
        check("l1_nbursts_out", 32'(nbursts[18 +: 18]), 32'd1000);
        csr_wr(14'h17, 32'd1);
        check("layer_en_both", 32'(layer_en), 32'd3);

        // Nonexistent layer, undefined offset, unselected page
        csr_wr(14'h18, 32'hFFFF);
        csr_rd(14'h18, rd);
        check("l2_absent", rd, 32'd0);
        csr_rd(14'h0E, rd);
        check("undef_ofs", rd, 32'd0);
        csr_wr(14'h0401, 32'hAAA);
        csr_rd(14'h0401, rd);
        check("unsel_read", rd, 32'd0);
        csr_rd(14'h01, rd);
        check("unsel_no_write", rd, 32'd1024);

        // DDC open-drain and input synchroniser
        csr_wr(14'h0A, 32'h4);
        check("sda_driven_low", 32'(sda_w), 32'd0);
        repeat (2) @(posedge sys_clk);
        csr_rd(14'h0A, rd);
        check("ddc_rd_low", rd, 32'h4);
        csr_wr(14'h0A, 32'h6);
        check("sda_released6", 32'(sda_w), 32'd1);
        repeat (2) @(posedge sys_clk);
        csr_rd(14'h0A, rd);
        check("ddc_rd_high", rd, 32'h7);
        csr_wr(14'h0A, 32'h2);
        check("sda_released2", 32'(sda_w), 32'd1);
        @(negedge sys_clk);
        tb_pull = 1'b1;
        repeat (2) @(posedge sys_clk);
        csr_rd(14'h0A, rd);
        check("ddc_rd_ext_low", rd, 32'h2);
        tb_pull = 1'b0;
        csr_wr(14'h0A, 32'h8);
        check("sdc_high", 32'(vga_sdc), 32'd1);

        csr_wr(14'h0B, 32'd2);
        check("clksel_out", 32'(clksel), 32'd2);

        // vga_rst forces the shadow copy
        csr_wr(14'h05, 32'd600);
        @(posedge sys_clk);
        #1 check("vres_held", 32'(vres), 32'd480);
        csr_wr(14'h00, 32'd1);
        check("vres_before_copy", 32'(vres), 32'd480);
        @(posedge sys_clk);
        #1 check("vres_rst_copy", 32'(vres), 32'd600);

        // Asynchronous reset mid-frame
        csr_wr(14'h0D, 32'd1);
        pulse_fs();
        @(posedge sys_clk);
        #1 check("irq_frame", 32'(irq), 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_hres", 32'(hres), 32'd640);
        check("arst_vres", 32'(vres), 32'd480);
        check("arst_layer_en", 32'(layer_en), 32'd1);
        check("arst_clksel", 32'(clksel), 32'd0);
        check("arst_l1_base", 32'(baseaddress[FD +: FD]), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        csr_rd(14'h05, rd);
        check("arst_vres_shadow", rd, 32'd480);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
